// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer read arbiter: default widths,
// framebuffer geometry, slot owner tags, B-side FSM encodings and the
// in-flight tag record carried alongside each memory read.
package fb_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 3;

    // Stored framebuffer geometry; the scanout upscales it to 640x480,
    // so PX_WIDTH*PX_HEIGHT fits in ADDR_W_DEF address bits.
    localparam int PX_WIDTH  = 160;
    localparam int PX_HEIGHT = 120;

    localparam logic TAG_A = 1'b0;
    localparam logic TAG_B = 1'b1;

    typedef enum logic [1:0] {
        B_IDLE   = 2'd0,
        B_WAIT   = 2'd1,
        B_ISSUED = 2'd2
    } b_state_t;

    // valid : a read was issued in this slot
    // owner : who receives the data (TAG_A / TAG_B)
    // miss  : A asked for this slot but B took it; A repeats its last pixel
    typedef struct packed {
        logic valid;
        logic owner;
        logic miss;
    } slot_tag_t;

    localparam int TAG_W = $bits(slot_tag_t);

endpackage

// File: rtl/arb_lat_pipe.sv
// Delay line for slot tags. It runs alongside the renderer read port so
// each tag reaches the tail in the same cycle its read data arrives.
module arb_lat_pipe
    import fb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [TAG_W-1:0] d,
    output logic [TAG_W-1:0] q
);

    logic [TAG_W-1:0] stage [DEPTH];

    // Shift tags one stage per cycle; clearing drops every in-flight read.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/fb_read_arbiter.sv
// Framebuffer read-port arbiter. Port A (scanout) has strict priority and
// a fixed MEM_LAT+1 latency. Port B is a req/ack reader served in A-idle
// slots, with one read in flight at most.
// Optional feature: define FBARB_FAIR_EN to let a starved B take a single
// slot from A; A then gets a_miss and repeats its last pixel.
//
//  state    | meaning
//  ---------+----------------------------------------------------
//  B_IDLE   | no B transaction open
//  B_WAIT   | b_req seen, waiting for a free slot (wait counter runs)
//  B_ISSUED | B read issued, waiting for its tag at the pipe tail
module fb_read_arbiter
    import fb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              a_en,
    input  logic [ADDR_W-1:0] a_addr,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_data,
    output logic              a_miss,
    input  logic              b_req,
    input  logic [ADDR_W-1:0] b_addr,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_data,
    output logic              b_starve,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    b_state_t          b_state;
    logic [CNT_W-1:0]  wait_cnt;
    slot_tag_t         iss_tag;
    slot_tag_t         ret_tag;
    logic [TAG_W-1:0]  ret_tag_bits;
    logic [DATA_W-1:0] a_hold;
    logic [DATA_W-1:0] b_hold;

    logic b_ready;
    logic force_b;
    logic grant_a;
    logic grant_b;
    logic a_fresh;

    // B competes only while waiting with the request still held; a dropped
    // request in B_WAIT is an abandon, not a grant.
    assign b_ready  = (b_state == B_WAIT) && b_req;
    assign b_starve = (wait_cnt == CNT_MAX);

`ifdef FBARB_FAIR_EN
    assign force_b = b_ready && b_starve && a_en;
    assign a_miss  = ret_tag.valid && ret_tag.miss;
`else
    assign force_b = 1'b0;
    assign a_miss  = 1'b0;
`endif

    assign grant_b = b_ready && (!a_en || force_b);
    assign grant_a = a_en && !grant_b;

    // Register the winning address and its tag; idle slots keep mem_addr.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            mem_addr <= '0;
            iss_tag  <= '0;
        end else begin
            if (grant_b) begin
                mem_addr <= b_addr;
            end else if (grant_a) begin
                mem_addr <= a_addr;
            end
            iss_tag.valid <= grant_a || grant_b;
            iss_tag.owner <= grant_b ? TAG_B : TAG_A;
            iss_tag.miss  <= grant_b && a_en;
        end
    end

    arb_lat_pipe #(
        .DEPTH (MEM_LAT)
    ) u_lat_pipe (
        .clk (clk),
        .clr (clr),
        .d   (iss_tag),
        .q   (ret_tag_bits)
    );

    assign ret_tag = slot_tag_t'(ret_tag_bits);

    // Route returning data by the tail tag. A stolen A slot still reports
    // valid so scanout timing never slips, but carries the previous pixel.
    assign a_fresh  = ret_tag.valid && (ret_tag.owner == TAG_A);
    assign a_rvalid = a_fresh || (ret_tag.valid && ret_tag.miss);
    assign a_data   = a_fresh ? mem_rdata : a_hold;
    assign b_ack    = ret_tag.valid && (ret_tag.owner == TAG_B);
    assign b_data   = b_ack ? mem_rdata : b_hold;

    // Remember the last delivered pixel per port for hold / repeat.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            a_hold <= '0;
            b_hold <= '0;
        end else begin
            if (a_fresh) begin
                a_hold <= mem_rdata;
            end
            if (b_ack) begin
                b_hold <= mem_rdata;
            end
        end
    end

    // B transaction FSM and saturating wait counter.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            b_state  <= B_IDLE;
            wait_cnt <= '0;
        end else begin
            case (b_state)
                B_IDLE: begin
                    wait_cnt <= '0;
                    if (b_req) begin
                        b_state <= B_WAIT;
                    end
                end
                B_WAIT: begin
                    if (grant_b) begin
                        b_state  <= B_ISSUED;
                        wait_cnt <= '0;
                    end else if (!b_req) begin
                        b_state  <= B_IDLE;
                        wait_cnt <= '0;
                    end else if (wait_cnt != CNT_MAX) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                B_ISSUED: begin
                    wait_cnt <= '0;
                    if (b_ack) begin
                        b_state <= B_IDLE;
                    end
                end
                default: begin
                    b_state  <= B_IDLE;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fb_read_arbiter.sv
// Self-checking bench for fb_read_arbiter: directed table, hand-written
// corner sequences and a randomized run against a reference model built
// from the arbitration rules (return schedule indexed by cycle).
// Honours FBARB_FAIR_EN the same way the design does.
module tb_fb_read_arbiter;

    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 3;
    localparam int MEM_LAT    = 1;
    localparam int STARVE_MAX = 8;
    localparam int RING       = 64;

`ifdef FBARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              clr;
    logic              a_en;
    logic [ADDR_W-1:0] a_addr;
    logic              a_rvalid;
    logic [DATA_W-1:0] a_data;
    logic              a_miss;
    logic              b_req;
    logic [ADDR_W-1:0] b_addr;
    logic              b_ack;
    logic [DATA_W-1:0] b_data;
    logic              b_starve;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fb_read_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .MEM_LAT    (MEM_LAT),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .a_en      (a_en),
        .a_addr    (a_addr),
        .a_rvalid  (a_rvalid),
        .a_data    (a_data),
        .a_miss    (a_miss),
        .b_req     (b_req),
        .b_addr    (b_addr),
        .b_ack     (b_ack),
        .b_data    (b_data),
        .b_starve  (b_starve),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata)
    );

    function automatic logic [DATA_W-1:0] memf(input logic [ADDR_W-1:0] a);
        return DATA_W'(int'(a) * 5 + (int'(a) >> 3) + 3);
    endfunction

    // Renderer read port: data MEM_LAT cycles after mem_addr.
    logic [DATA_W-1:0] lat_q [MEM_LAT];
    always_ff @(posedge clk) begin
        lat_q[0] <= memf(mem_addr);
        for (int k = 1; k < MEM_LAT; k++) lat_q[k] <= lat_q[k-1];
    end
    assign mem_rdata = lat_q[MEM_LAT-1];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", nm, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int cyc;
    int ra_kind [RING];   // 0 none, 1 A data, 2 A miss
    int ra_addr [RING];
    bit rb_v    [RING];
    int rb_adr  [RING];
    bit m_bwait, m_binfl, m_eack;
    int m_wcnt, m_madr, m_la, m_lb;

    task automatic model_reset();
        cyc = 0; m_bwait = 0; m_binfl = 0; m_eack = 0;
        m_wcnt = 0; m_madr = 0; m_la = 0; m_lb = 0;
        for (int i = 0; i < RING; i++) begin
            ra_kind[i] = 0; ra_addr[i] = 0; rb_v[i] = 0; rb_adr[i] = 0;
        end
    endtask

    task automatic model_cycle(input bit ae, input int aa, input bit br, input int ba);
        int s, d;
        bit eb_ack, starve, gb, ga;
        s = cyc % RING;
        if (ra_kind[s] == 1) m_la = int'(memf(ADDR_W'(ra_addr[s])));
        eb_ack = rb_v[s];
        if (eb_ack) m_lb = int'(memf(ADDR_W'(rb_adr[s])));
        starve = (m_wcnt >= STARVE_MAX);
        chk("a_rvalid", int'(a_rvalid), int'(ra_kind[s] != 0));
        chk("a_data",   int'(a_data),   m_la);
        chk("a_miss",   int'(a_miss),   int'(ra_kind[s] == 2));
        chk("b_ack",    int'(b_ack),    int'(eb_ack));
        chk("b_data",   int'(b_data),   m_lb);
        chk("b_starve", int'(b_starve), int'(starve));
        chk("mem_addr", int'(mem_addr), m_madr);
        ra_kind[s] = 0;
        rb_v[s]    = 0;
        gb = m_bwait && br && (!ae || (FAIR && starve));
        ga = ae && !gb;
        d = (cyc + 1 + MEM_LAT) % RING;
        if (gb) begin
            rb_v[d] = 1; rb_adr[d] = ba; m_madr = ba;
            if (ae) ra_kind[d] = 2;
        end else if (ga) begin
            ra_kind[d] = 1; ra_addr[d] = aa; m_madr = aa;
        end
        if (m_binfl) begin
            if (eb_ack) m_binfl = 0;
        end else if (!m_bwait) begin
            if (br) m_bwait = 1;
        end else if (gb) begin
            m_bwait = 0; m_binfl = 1; m_wcnt = 0;
        end else if (!br) begin
            m_bwait = 0; m_wcnt = 0;
        end else if (m_wcnt < STARVE_MAX) begin
            m_wcnt++;
        end
        m_eack = eb_ack;
        cyc++;
    endtask

    task automatic tick(input bit ae, input logic [ADDR_W-1:0] aa,
                        input bit br, input logic [ADDR_W-1:0] ba);
        @(posedge clk);
        #1;
        a_en = ae; a_addr = aa; b_req = br; b_addr = ba;
        @(negedge clk);
        model_cycle(ae, int'(aa), br, int'(ba));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_a_rvalid"}, int'(a_rvalid), 0);
        chk({tag, "_a_data"},   int'(a_data),   0);
        chk({tag, "_a_miss"},   int'(a_miss),   0);
        chk({tag, "_b_ack"},    int'(b_ack),    0);
        chk({tag, "_b_data"},   int'(b_data),   0);
        chk({tag, "_b_starve"}, int'(b_starve), 0);
        chk({tag, "_mem_addr"}, int'(mem_addr), 0);
    endtask

    // Assert clr between edges, check outputs, release at a negedge and
    // run the release cycle through the model with the inputs still driven.
    task automatic do_reset();
        @(negedge clk);
        clr = 1'b0;
        model_reset();
        #1;
        chk_zero("rst");
        @(negedge clk);
        chk_zero("rst_hold");
        clr = 1'b1;
        model_cycle(a_en, int'(a_addr), b_req, int'(b_addr));
    endtask

    typedef struct {
        bit                ae;
        logic [ADDR_W-1:0] aa;
        bit                br;
        logic [ADDR_W-1:0] ba;
        bit                e_rv;
        bit                e_ack;
        logic [ADDR_W-1:0] e_madr;
        logic [ADDR_W-1:0] e_dadr;
    } vec_t;

    vec_t vt [15];

    initial begin
        bit rb;
        logic [ADDR_W-1:0] rba;
        int ackc;

        vt[0]  = '{0, 16'd0, 1, 16'd100, 0, 0, 16'd0,   16'd0};
        vt[1]  = '{0, 16'd0, 1, 16'd100, 0, 0, 16'd0,   16'd0};
        vt[2]  = '{0, 16'd0, 1, 16'd100, 0, 0, 16'd100, 16'd0};
        vt[3]  = '{0, 16'd0, 1, 16'd100, 0, 1, 16'd100, 16'd100};
        vt[4]  = '{0, 16'd0, 1, 16'd101, 0, 0, 16'd100, 16'd0};
        vt[5]  = '{0, 16'd0, 1, 16'd101, 0, 0, 16'd100, 16'd0};
        vt[6]  = '{0, 16'd0, 0, 16'd101, 0, 0, 16'd101, 16'd0};
        vt[7]  = '{0, 16'd0, 0, 16'd0,   0, 1, 16'd101, 16'd101};
        vt[8]  = '{1, 16'd5, 0, 16'd0,   0, 0, 16'd101, 16'd0};
        vt[9]  = '{0, 16'd0, 0, 16'd0,   0, 0, 16'd5,   16'd0};
        vt[10] = '{0, 16'd0, 0, 16'd0,   1, 0, 16'd5,   16'd5};
        vt[11] = '{0, 16'd0, 1, 16'd7,   0, 0, 16'd5,   16'd0};
        vt[12] = '{0, 16'd0, 0, 16'd7,   0, 0, 16'd5,   16'd0};
        vt[13] = '{0, 16'd0, 0, 16'd0,   0, 0, 16'd5,   16'd0};
        vt[14] = '{0, 16'd0, 0, 16'd0,   0, 0, 16'd5,   16'd0};

        clr = 1'b0; a_en = 0; a_addr = '0; b_req = 0; b_addr = '0;
        do_reset();

        // Directed table: B transactions, held request, A read, abandon.
        for (int i = 0; i < 15; i++) begin
            tick(vt[i].ae, vt[i].aa, vt[i].br, vt[i].ba);
            chk("tbl_rvalid", int'(a_rvalid), int'(vt[i].e_rv));
            chk("tbl_ack",    int'(b_ack),    int'(vt[i].e_ack));
            chk("tbl_madr",   int'(mem_addr), int'(vt[i].e_madr));
            if (vt[i].e_rv)  chk("tbl_adata", int'(a_data), int'(memf(vt[i].e_dadr)));
            if (vt[i].e_ack) chk("tbl_bdata", int'(b_data), int'(memf(vt[i].e_dadr)));
        end

        // A only, addresses 0..9 back to back.
        for (int i = 0; i < 12; i++) begin
            tick(i < 10, ADDR_W'(i), 0, '0);
            chk("aonly_ack", int'(b_ack), 0);
            if (i >= 2) begin
                chk("aonly_rv",   int'(a_rvalid), 1);
                chk("aonly_data", int'(a_data), int'(memf(ADDR_W'(i - 2))));
            end
        end

        // Contention: a_en for 20 cycles, b_req from cycle 2.
        a_en = 0; b_req = 0;
        do_reset();
        ackc = FAIR ? 13 : 22;
        for (int c = 0; c < 26; c++) begin
            tick(c < 20, ADDR_W'(200 + c), (c >= 2 && c <= ackc), 16'd300);
            chk("cont_ack", int'(b_ack), int'(c == ackc));
            if (c == 10) chk("cont_starve_pre", int'(b_starve), 0);
            if (c == 11) chk("cont_starve_hit", int'(b_starve), 1);
            if (c == ackc) chk("cont_bdata", int'(b_data), int'(memf(16'd300)));
            if (FAIR) begin
                chk("fair_miss", int'(a_miss), int'(c == 13));
                if (c == 12) chk("fair_starve_clr", int'(b_starve), 0);
                if (c == 13) chk("fair_repeat", int'(a_data), int'(memf(16'd210)));
            end else begin
                chk("strict_miss", int'(a_miss), 0);
                if (c == 20) chk("strict_starve_hold", int'(b_starve), 1);
                if (c == 21) chk("strict_starve_clr", int'(b_starve), 0);
            end
            if (c >= 2 && c <= 21) begin
                chk("cont_rv", int'(a_rvalid), 1);
                if (!(FAIR && c == 13))
                    chk("cont_adata", int'(a_data), int'(memf(ADDR_W'(200 + c - 2))));
            end
        end

        // Reset while B_ISSUED, request held across release.
        tick(0, '0, 0, '0);
        tick(0, '0, 1, 16'd400);
        tick(0, '0, 1, 16'd400);
        do_reset();
        tick(0, '0, 1, 16'd400);
        chk("rst_stale_ack1", int'(b_ack), 0);
        tick(0, '0, 1, 16'd400);
        chk("rst_stale_ack2", int'(b_ack), 0);
        tick(0, '0, 1, 16'd400);
        chk("rst_restart_ack", int'(b_ack), 1);
        chk("rst_restart_data", int'(b_data), int'(memf(16'd400)));
        tick(0, '0, 0, '0);

        // Randomized traffic with alternating heavy / light A load.
        rb = 0; rba = '0;
        for (int i = 0; i < 800; i++) begin
            bit hi, ae;
            logic [ADDR_W-1:0] aa;
            hi = ((i / 40) % 2) == 0;
            ae = hi ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 9) < 4);
            aa = ADDR_W'($urandom_range(0, 19199));
            if (!rb) begin
                if ($urandom_range(0, 3) == 0) begin
                    rb = 1; rba = ADDR_W'($urandom_range(0, 19199));
                end
            end else if (m_eack) begin
                if ($urandom_range(0, 1) == 0) rb = 0;
                else rba = ADDR_W'($urandom_range(0, 19199));
            end else if ($urandom_range(0, 39) == 0) begin
                rb = 0;
            end
            tick(ae, aa, rb, rba);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
